// File: rtl/exc_ctrl_if.sv
// Bundle of MEM-stage exception inputs, CP0 exception outputs and the fetch redirect handshake.
interface exc_ctrl_if;
    logic        mem_valid;
    logic [31:0] mem_pc;
    logic        mem_in_delay_slot;
    logic        mem_ri;
    logic        mem_ov;
    logic        mem_syscall;
    logic        mem_break;
    logic        mem_eret;
    logic        mem_adel;
    logic        mem_ades;
    logic [31:0] mem_badaddr;
    logic [31:0] status_i;
    logic [31:0] cause_i;
    logic [31:0] epc_i;
    logic        wb_cp0_we;
    logic [4:0]  wb_cp0_addr;
    logic [31:0] wb_cp0_data;
    logic [4:0]  exc_type_o;
    logic [31:0] exc_pc_o;
    logic        exc_in_delay_slot_o;
    logic [31:0] exc_badaddr_o;
    logic        exc_we_mem_o;
    logic        flush_o;
    logic        stall_o;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;
    logic        redirect_ready_i;

    modport master (
        input  mem_valid, mem_pc, mem_in_delay_slot, mem_ri, mem_ov, mem_syscall,
               mem_break, mem_eret, mem_adel, mem_ades, mem_badaddr,
               status_i, cause_i, epc_i, wb_cp0_we, wb_cp0_addr, wb_cp0_data,
               redirect_ready_i,
        output exc_type_o, exc_pc_o, exc_in_delay_slot_o, exc_badaddr_o, exc_we_mem_o,
               flush_o, stall_o, redirect_valid_o, redirect_pc_o
    );

    modport slave (
        output mem_valid, mem_pc, mem_in_delay_slot, mem_ri, mem_ov, mem_syscall,
               mem_break, mem_eret, mem_adel, mem_ades, mem_badaddr,
               status_i, cause_i, epc_i, wb_cp0_we, wb_cp0_addr, wb_cp0_data,
               redirect_ready_i,
        input  exc_type_o, exc_pc_o, exc_in_delay_slot_o, exc_badaddr_o, exc_we_mem_o,
               flush_o, stall_o, redirect_valid_o, redirect_pc_o
    );
endinterface

// File: rtl/exc_ctrl.sv
// Exception arbiter and redirect sequencer at the MEM/WB boundary (CP0 producer side).
// Optional EXC_CNT_EN adds a free-running committed-exception counter exc_count_o.
module exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rest,
    exc_ctrl_if.master     bus
`ifdef EXC_CNT_EN
    ,
    output logic [31:0]    exc_count_o
`endif
);
    localparam int unsigned CNT_W = 4;
    localparam int unsigned DW    = 32;
    localparam logic [4:0] EXC_NONE = 5'b11111;
    localparam logic [4:0] EXC_INT  = 5'b10111;
    localparam logic [4:0] EXC_ADDR = 5'b00001;
    localparam logic [4:0] EXC_RI   = 5'b10101;
    localparam logic [4:0] EXC_OV   = 5'b00010;
    localparam logic [4:0] EXC_SYS  = 5'b00011;
    localparam logic [4:0] EXC_BRK  = 5'b00100;
    localparam logic [4:0] EXC_ERET = 5'b00101;
    localparam logic [CNT_W-1:0] FLUSH_RELOAD =
        CNT_W'((FLUSH_CYCLES >= 2) ? (FLUSH_CYCLES - 2) : 0);

    typedef enum logic [1:0] {IDLE, COMMIT, FLUSH, REDIRECT} state_e;

    state_e          state_q, state_d;
    logic [4:0]      exc_type_q, exc_type_d;
    logic [DW-1:0]   exc_pc_q, exc_pc_d;
    logic            exc_ds_q, exc_ds_d;
    logic [DW-1:0]   exc_bad_q, exc_bad_d;
    logic            exc_we_q, exc_we_d;
    logic            flush_q, flush_d;
    logic            stall_q, stall_d;
    logic            rv_q, rv_d;
    logic [DW-1:0]   rpc_q, rpc_d;
    logic [CNT_W-1:0] fcnt_q, fcnt_d;
`ifdef EXC_CNT_EN
    logic [DW-1:0]   cnt_q, cnt_d;
`endif

    logic            int_pend, pc_mis, ev_hit, ev_eret;
    logic [4:0]      ev_type;
    logic [DW-1:0]   ev_badaddr, eret_target;
    logic            ev_we_mem;
    logic            unused_bits;

    assign unused_bits = ^{bus.status_i[31:16], bus.status_i[7:2],
                           bus.cause_i[31:16], bus.cause_i[7:0]};

    // Fixed-priority selection of the single event raised by the MEM instruction
    always_comb begin
        int_pend    = bus.status_i[0] & ~bus.status_i[1] &
                      (|(bus.cause_i[15:8] & bus.status_i[15:8]));
        pc_mis      = bus.mem_pc[1:0] != 2'b00;
        eret_target = (bus.wb_cp0_we && bus.wb_cp0_addr == 5'd14) ? bus.wb_cp0_data : bus.epc_i;
        ev_hit      = 1'b1;
        ev_type     = EXC_NONE;
        ev_badaddr  = '0;
        ev_we_mem   = 1'b0;
        ev_eret     = 1'b0;
        if (int_pend) begin
            ev_type = EXC_INT;
        end else if (pc_mis) begin
            ev_type    = EXC_ADDR;
            ev_badaddr = bus.mem_pc;
        end else if (bus.mem_ri) begin
            ev_type = EXC_RI;
        end else if (bus.mem_ov) begin
            ev_type = EXC_OV;
        end else if (bus.mem_syscall) begin
            ev_type = EXC_SYS;
        end else if (bus.mem_break) begin
            ev_type = EXC_BRK;
        end else if (bus.mem_adel || bus.mem_ades) begin
            ev_type    = EXC_ADDR;
            ev_badaddr = bus.mem_badaddr;
            ev_we_mem  = bus.mem_ades;
        end else if (bus.mem_eret) begin
            ev_type = EXC_ERET;
            ev_eret = 1'b1;
        end else begin
            ev_hit = 1'b0;
        end
    end

    // Sequencer next-state: COMMIT -> FLUSH (FLUSH_CYCLES-1) -> REDIRECT handshake
    always_comb begin
        state_d    = state_q;
        exc_type_d = exc_type_q;
        exc_pc_d   = exc_pc_q;
        exc_ds_d   = exc_ds_q;
        exc_bad_d  = exc_bad_q;
        exc_we_d   = exc_we_q;
        flush_d    = flush_q;
        stall_d    = stall_q;
        rv_d       = rv_q;
        rpc_d      = rpc_q;
        fcnt_d     = fcnt_q;
`ifdef EXC_CNT_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.mem_valid && ev_hit) begin
                    state_d    = COMMIT;
                    exc_type_d = ev_type;
                    exc_pc_d   = bus.mem_pc;
                    exc_ds_d   = bus.mem_in_delay_slot;
                    exc_bad_d  = ev_badaddr;
                    exc_we_d   = ev_we_mem;
                    flush_d    = 1'b1;
                    stall_d    = 1'b1;
                    rpc_d      = ev_eret ? eret_target : EXC_VECTOR;
                end
            end
            COMMIT: begin
                exc_type_d = EXC_NONE;
`ifdef EXC_CNT_EN
                cnt_d      = cnt_q + 32'd1;
`endif
                if (FLUSH_CYCLES <= 1) begin
                    state_d = REDIRECT;
                    flush_d = 1'b0;
                    rv_d    = 1'b1;
                end else begin
                    state_d = FLUSH;
                    fcnt_d  = FLUSH_RELOAD;
                end
            end
            FLUSH: begin
                if (fcnt_q == '0) begin
                    state_d = REDIRECT;
                    flush_d = 1'b0;
                    rv_d    = 1'b1;
                end else begin
                    fcnt_d = fcnt_q - CNT_W'(1);
                end
            end
            REDIRECT: begin
                if (bus.redirect_ready_i) begin
                    state_d = IDLE;
                    rv_d    = 1'b0;
                    stall_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rest) begin
            state_q    <= IDLE;
            exc_type_q <= EXC_NONE;
            exc_pc_q   <= '0;
            exc_ds_q   <= 1'b0;
            exc_bad_q  <= '0;
            exc_we_q   <= 1'b0;
            flush_q    <= 1'b0;
            stall_q    <= 1'b0;
            rv_q       <= 1'b0;
            rpc_q      <= '0;
            fcnt_q     <= '0;
`ifdef EXC_CNT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            exc_type_q <= exc_type_d;
            exc_pc_q   <= exc_pc_d;
            exc_ds_q   <= exc_ds_d;
            exc_bad_q  <= exc_bad_d;
            exc_we_q   <= exc_we_d;
            flush_q    <= flush_d;
            stall_q    <= stall_d;
            rv_q       <= rv_d;
            rpc_q      <= rpc_d;
            fcnt_q     <= fcnt_d;
`ifdef EXC_CNT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign bus.exc_type_o          = exc_type_q;
    assign bus.exc_pc_o            = exc_pc_q;
    assign bus.exc_in_delay_slot_o = exc_ds_q;
    assign bus.exc_badaddr_o       = exc_bad_q;
    assign bus.exc_we_mem_o        = exc_we_q;
    assign bus.flush_o             = flush_q;
    assign bus.stall_o             = stall_q;
    assign bus.redirect_valid_o    = rv_q;
    assign bus.redirect_pc_o       = rpc_q;
`ifdef EXC_CNT_EN
    assign exc_count_o             = cnt_q;
`endif
endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: vector table plus hand sequences, commits checked via a scoreboard queue.
module tb_exc_ctrl;
    localparam logic [31:0] VEC = 32'hBFC00380;

    typedef struct {
        logic [31:0] status, cause, pc, badaddr, epc, wb_data;
        logic        valid, ds, wb_we;
        logic [4:0]  wb_addr;
        logic [6:0]  flags;     // ri ov sys brk adel ades eret
        logic [4:0]  e_type;
        logic [31:0] e_bad;
        logic        e_we;
        logic [31:0] e_rpc;
    } vec_t;

    typedef struct {
        logic [4:0]  typ;
        logic [31:0] pc;
        logic        ds;
        logic [31:0] bad;
        logic        we;
    } exp_t;

    logic clk = 1'b0;
    logic rest;
    int   checks = 0;
    int   errors = 0;
    int   exp_cnt = 0;
    exp_t exp_q[$];
    vec_t vecs[14];

    exc_ctrl_if bus ();
`ifdef EXC_CNT_EN
    logic [31:0] exc_count;
`endif

    exc_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(2)) dut (
        .clk(clk),
        .rest(rest),
        .bus(bus)
`ifdef EXC_CNT_EN
        ,
        .exc_count_o(exc_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Any non-none exc_type_o must match the oldest expected commit
    task automatic monitor();
        exp_t e;
        if (bus.exc_type_o !== 5'h1f) begin
            if (exp_q.size() == 0) begin
                check("unexpected_commit", 32'(bus.exc_type_o), 32'h1f);
            end else begin
                e = exp_q.pop_front();
                exp_cnt++;
                check("exc_type", 32'(bus.exc_type_o), 32'(e.typ));
                check("exc_pc", bus.exc_pc_o, e.pc);
                check("exc_ds", 32'(bus.exc_in_delay_slot_o), 32'(e.ds));
                check("exc_badaddr", bus.exc_badaddr_o, e.bad);
                check("exc_we_mem", 32'(bus.exc_we_mem_o), 32'(e.we));
                check("commit_flush", 32'(bus.flush_o), 32'h1);
                check("commit_stall", 32'(bus.stall_o), 32'h1);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        monitor();
    endtask

    task automatic clear_inputs();
        bus.mem_valid = 0; bus.mem_pc = 0; bus.mem_in_delay_slot = 0;
        bus.mem_ri = 0; bus.mem_ov = 0; bus.mem_syscall = 0; bus.mem_break = 0;
        bus.mem_eret = 0; bus.mem_adel = 0; bus.mem_ades = 0; bus.mem_badaddr = 0;
        bus.status_i = 0; bus.cause_i = 0; bus.epc_i = 0;
        bus.wb_cp0_we = 0; bus.wb_cp0_addr = 0; bus.wb_cp0_data = 0;
    endtask

    function automatic vec_t mk(logic [31:0] status, logic [31:0] cause, logic valid,
                                logic [31:0] pc, logic ds, logic [6:0] flags,
                                logic [31:0] badaddr, logic [31:0] epc, logic wb_we,
                                logic [4:0] wb_addr, logic [31:0] wb_data,
                                logic [4:0] e_type, logic [31:0] e_bad, logic e_we,
                                logic [31:0] e_rpc);
        vec_t v;
        v.status = status; v.cause = cause; v.valid = valid; v.pc = pc; v.ds = ds;
        v.flags = flags; v.badaddr = badaddr; v.epc = epc; v.wb_we = wb_we;
        v.wb_addr = wb_addr; v.wb_data = wb_data; v.e_type = e_type; v.e_bad = e_bad;
        v.e_we = e_we; v.e_rpc = e_rpc;
        return v;
    endfunction

    task automatic drive_and_push(input vec_t v);
        exp_t e;
        bus.status_i = v.status; bus.cause_i = v.cause; bus.mem_valid = v.valid;
        bus.mem_pc = v.pc; bus.mem_in_delay_slot = v.ds; bus.mem_badaddr = v.badaddr;
        {bus.mem_ri, bus.mem_ov, bus.mem_syscall, bus.mem_break,
         bus.mem_adel, bus.mem_ades, bus.mem_eret} = v.flags;
        bus.epc_i = v.epc; bus.wb_cp0_we = v.wb_we; bus.wb_cp0_addr = v.wb_addr;
        bus.wb_cp0_data = v.wb_data;
        if (v.e_type != 5'h1f) begin
            e.typ = v.e_type; e.pc = v.pc; e.ds = v.ds; e.bad = v.e_bad; e.we = v.e_we;
            exp_q.push_back(e);
        end
    endtask

    // From the COMMIT cycle onward: measure flush length, then complete the redirect
    task automatic finish_seq(input logic [31:0] rpc);
        int n = 0;
        check("commit_seen", 32'(exp_q.size()), 32'h0);
        while (bus.flush_o && n < 20) begin
            n++;
            tick();
        end
        check("flush_len", 32'(n), 32'd2);
        check("redirect_valid", 32'(bus.redirect_valid_o), 32'h1);
        check("redirect_pc", bus.redirect_pc_o, rpc);
        check("redirect_stall", 32'(bus.stall_o), 32'h1);
        bus.redirect_ready_i = 1;
        tick();
        bus.redirect_ready_i = 0;
        check("post_redirect_valid", 32'(bus.redirect_valid_o), 32'h0);
        check("post_redirect_stall", 32'(bus.stall_o), 32'h0);
    endtask

    task automatic apply(input vec_t v);
        drive_and_push(v);
        tick();
        clear_inputs();
        if (v.e_type == 5'h1f) begin
            check("no_event_type", 32'(bus.exc_type_o), 32'h1f);
            check("no_event_flush", 32'(bus.flush_o), 32'h0);
            check("no_event_stall", 32'(bus.stall_o), 32'h0);
        end else begin
            finish_seq(v.e_rpc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        vecs[0]  = mk(0, 0, 1, 32'h80001000, 0, 7'b0100000, 0, 0, 0, 0, 0, 5'h02, 0, 0, VEC);
        vecs[1]  = mk(0, 0, 1, 32'h80001004, 0, 7'b1000010, 32'h12345671, 0, 0, 0, 0, 5'h15, 0, 0, VEC);
        vecs[2]  = mk(32'h401, 32'h400, 1, 32'h80001008, 0, 7'b0010000, 0, 0, 0, 0, 0, 5'h17, 0, 0, VEC);
        vecs[3]  = mk(32'h403, 32'h400, 1, 32'h8000100C, 0, 7'b0010000, 0, 0, 0, 0, 0, 5'h03, 0, 0, VEC);
        vecs[4]  = mk(0, 0, 1, 32'h80001010, 0, 7'b0000001, 0, 32'h80002000, 1, 5'd14, 32'h80003000,
                      5'h05, 0, 0, 32'h80003000);
        vecs[5]  = mk(0, 0, 1, 32'h80001010, 0, 7'b0000001, 0, 32'h80002000, 1, 5'd13, 32'h80003000,
                      5'h05, 0, 0, 32'h80002000);
        vecs[6]  = mk(0, 0, 1, 32'h80000002, 0, 7'b0000100, 32'h55, 0, 0, 0, 0, 5'h01, 32'h80000002, 0, VEC);
        vecs[7]  = mk(0, 0, 1, 32'h80001014, 0, 7'b0000110, 32'h10000003, 0, 0, 0, 0, 5'h01, 32'h10000003, 1, VEC);
        vecs[8]  = mk(0, 0, 1, 32'h80001018, 0, 7'b0000100, 32'h20000001, 0, 0, 0, 0, 5'h01, 32'h20000001, 0, VEC);
        vecs[9]  = mk(0, 0, 1, 32'h80000100, 1, 7'b0001000, 0, 0, 0, 0, 0, 5'h04, 0, 0, VEC);
        vecs[10] = mk(32'h401, 32'h400, 0, 32'h80001020, 0, 7'b0000000, 0, 0, 0, 0, 0, 5'h1f, 0, 0, 0);
        vecs[11] = mk(0, 0, 1, 32'h80001024, 0, 7'b0000000, 0, 0, 0, 0, 0, 5'h1f, 0, 0, 0);
        vecs[12] = mk(32'h201, 32'h400, 1, 32'h80001028, 0, 7'b0010000, 0, 0, 0, 0, 0, 5'h03, 0, 0, VEC);
        vecs[13] = mk(32'h400, 32'h400, 1, 32'h8000102C, 0, 7'b0100000, 0, 0, 0, 0, 0, 5'h02, 0, 0, VEC);

        clear_inputs();
        bus.redirect_ready_i = 0;
        rest = 1;
        tick();
        tick();
        check("rst_type", 32'(bus.exc_type_o), 32'h1f);
        check("rst_pc", bus.exc_pc_o, 0);
        check("rst_bad", bus.exc_badaddr_o, 0);
        check("rst_ds", 32'(bus.exc_in_delay_slot_o), 0);
        check("rst_we", 32'(bus.exc_we_mem_o), 0);
        check("rst_flush", 32'(bus.flush_o), 0);
        check("rst_stall", 32'(bus.stall_o), 0);
        check("rst_rv", 32'(bus.redirect_valid_o), 0);
        check("rst_rpc", bus.redirect_pc_o, 0);
        rest = 0;
        tick();

        for (int i = 0; i < 14; i++) apply(vecs[i]);
`ifdef EXC_CNT_EN
        check("exc_count", exc_count, 32'(exp_cnt));
`endif

        // Held redirect with an ignored overflow pulse inside the window
        v = mk(0, 0, 1, 32'h80004000, 0, 7'b0100000, 0, 0, 0, 0, 0, 5'h02, 0, 0, VEC);
        drive_and_push(v);
        tick();
        clear_inputs();
        for (int n = 0; n < 20 && !bus.redirect_valid_o; n++) tick();
        for (int i = 0; i < 10; i++) begin
            check("held_valid", 32'(bus.redirect_valid_o), 32'h1);
            check("held_stall", 32'(bus.stall_o), 32'h1);
            check("held_pc", bus.redirect_pc_o, VEC);
            bus.mem_valid = (i == 3); bus.mem_ov = (i == 3);
            tick();
        end
        clear_inputs();
        check("held_valid_end", 32'(bus.redirect_valid_o), 32'h1);
        bus.redirect_ready_i = 1;
        tick();
        bus.redirect_ready_i = 0;
        check("held_release_valid", 32'(bus.redirect_valid_o), 32'h0);
        check("held_release_stall", 32'(bus.stall_o), 32'h0);
        tick();
        tick();
        check("held_no_late_commit", 32'(bus.exc_type_o), 32'h1f);

        // Reset in the middle of FLUSH
        v = mk(0, 0, 1, 32'h80005000, 1, 7'b0100000, 0, 0, 0, 0, 0, 5'h02, 0, 0, VEC);
        drive_and_push(v);
        tick();
        clear_inputs();
        tick();
        check("mid_flush", 32'(bus.flush_o), 32'h1);
        rest = 1;
        tick();
        check("rf_type", 32'(bus.exc_type_o), 32'h1f);
        check("rf_pc", bus.exc_pc_o, 0);
        check("rf_ds", 32'(bus.exc_in_delay_slot_o), 0);
        check("rf_flush", 32'(bus.flush_o), 0);
        check("rf_stall", 32'(bus.stall_o), 0);
        check("rf_rv", 32'(bus.redirect_valid_o), 0);
        check("rf_rpc", bus.redirect_pc_o, 0);
`ifdef EXC_CNT_EN
        check("rf_count", exc_count, 0);
`endif
        rest = 0;
        tick();
        tick();
        tick();
        check("rf_idle_type", 32'(bus.exc_type_o), 32'h1f);
        check("rf_idle_flush", 32'(bus.flush_o), 0);
        check("rf_idle_rv", 32'(bus.redirect_valid_o), 0);
        check("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
